// File: rtl/nv_ram_rws_fifo_ctl_pkg.sv
// Shared defaults for the RAM-backed FIFO controller: word/address widths and
// the size of the prefetch buffer that hides the RAM read latency.
package nv_ram_rws_fifo_ctl_pkg;
    localparam int DW_DEFAULT = 256;
    localparam int AW_DEFAULT = 8;
    localparam int OB_DEPTH   = 2;

    typedef logic [1:0] ob_cnt_t;
endpackage

// File: rtl/nv_ram_rws_fifo_ctl_skid2.sv
// Two-entry output buffer fed by RAM read data; the head entry drives the pop
// interface and the tail absorbs one extra word while the consumer stalls.
module nv_fifo_skid2
    import nv_ram_rws_fifo_ctl_pkg::*;
#(
    parameter int DW = DW_DEFAULT
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_vld,
    input  logic [DW-1:0] cap_pd,
    input  logic          pop,
    output ob_cnt_t       ob_cnt,
    output logic [DW-1:0] head_pd
);
    ob_cnt_t       r_cnt;
    ob_cnt_t       w_left;
    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;

    // Entries remaining once this cycle's pop is taken into account.
    assign w_left = r_cnt - ob_cnt_t'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_left + ob_cnt_t'(cap_vld);
        end
    end

    // Payload registers need no reset: they are only observed when r_cnt says so.
    always_ff @(posedge clk) begin
        if (cap_vld && (w_left == '0)) begin
            r_head <= cap_pd;
        end else if (pop && (r_cnt == ob_cnt_t'(OB_DEPTH))) begin
            r_head <= r_tail;
        end
        if (cap_vld && (w_left != '0)) begin
            r_tail <= cap_pd;
        end
    end

    assign ob_cnt  = r_cnt;
    assign head_pd = r_head;
endmodule

// File: rtl/nv_ram_rws_fifo_ctl.sv
// FIFO controller around an external 1R1W RAM with a registered read address:
// pointer/occupancy bookkeeping, RAM strobes and read prefetch into a skid buffer.
module nv_ram_rws_fifo_ctl
    import nv_ram_rws_fifo_ctl_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW:0]   fifo_cnt,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_di,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_dout
);
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_ram_cnt;
    logic          r_inflight;

    logic          w_push;
    logic          w_pop;
    ob_cnt_t       w_ob_cnt;
    logic [2:0]    w_ob_need;

    assign wr_prdy = ~rst & (r_ram_cnt != FULL_CNT);
    assign w_push  = wr_pvld & wr_prdy;

    assign ram_we  = w_push;
    assign ram_wa  = r_wr_ptr;
    assign ram_di  = wr_pd;

    assign rd_pvld = (w_ob_cnt != '0);
    assign w_pop   = rd_pvld & rd_prdy;

    // Issue only if the word (plus any already in flight) still fits in the buffer.
    assign w_ob_need = {1'b0, w_ob_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign ram_re    = (r_ram_cnt != '0) & (w_ob_need < 3'(OB_DEPTH));
    assign ram_ra    = r_rd_ptr;

    assign fifo_cnt = r_ram_cnt + {{AW{1'b0}}, r_inflight}
                    + {{(AW-1){1'b0}}, w_ob_cnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= ram_re;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (ram_re) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !ram_re) begin
                r_ram_cnt <= r_ram_cnt + (AW+1)'(1);
            end else if (!w_push && ram_re) begin
                r_ram_cnt <= r_ram_cnt - (AW+1)'(1);
            end
        end
    end

    nv_fifo_skid2 #(
        .DW (DW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .cap_vld (r_inflight),
        .cap_pd  (ram_dout),
        .pop     (w_pop),
        .ob_cnt  (w_ob_cnt),
        .head_pd (rd_pd)
    );
endmodule
